regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with write-first bypass and a per-register pending-write scoreboard, the pipelined-core successor to the single-cycle core's two-port register file. It sits in the ID stage. Read ports are registered, giving 1-cycle latency. Writeback from WB writes the array and bypasses to a same-cycle read. An issue port marks destination registers busy until their writeback lands, so ID can detect RAW hazards without a separate hazard table.

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_mp_if : bundle of read, writeback, issue and flush signals for     |
// |                 regfile_mp                                                  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ-1:0]            rd_en;
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           iss_en;
  logic [ADDR_WIDTH-1:0]          iss_addr;
  logic                           flush;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_mp : multi-read-port register file with write-first bypass and a   |
// |              per-register pending-write scoreboard                          |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  wire          clk,
  input  wire          reset_n,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic w_wr_ok;
  logic w_iss_ok;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign w_wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
  assign w_iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  // Later assignments win: flush over issue over writeback.
  always_comb begin
    pend_d = pend_q;
    if (w_wr_ok) begin
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (w_iss_ok) begin
      pend_d[bus.iss_addr] = 1'b1;
    end
    if (bus.flush) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  generate
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_zero;
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] rd_data_d;
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_busy_d;
      logic                  rd_busy_q;

      assign w_addr    = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_zero    = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit     = w_wr_ok && (bus.wr_addr == w_addr);
      assign rd_data_d = w_zero ? '0 : (w_hit ? bus.wr_data : mem_q[w_addr]);
      // Busy reflects the post-update scoreboard so same-cycle issue/writeback is seen.
      assign rd_busy_d = pend_d[w_addr];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_data_q <= '0;
          rd_busy_q <= 1'b0;
        end else if (bus.rd_en[i]) begin
          rd_data_q <= rd_data_d;
          rd_busy_q <= rd_busy_d;
        end
      end

      assign bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
      assign bus.rd_busy[i]                          = rd_busy_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_mp : vector table, corner sequences and random traffic against  |
// |                 a register-file reference model                            |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string            name;
    logic [NR-1:0]    en;
    logic [NR*AW-1:0] ra;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic             ie;
    logic [AW-1:0]    ia;
    logic             fl;
    int               cp;   // port to hand-check, -1 for none
    logic [DW-1:0]    ed;
    logic             eb;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: architectural registers, pending set, visible outputs
  logic [DW-1:0]    m_mem  [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic [DW-1:0]    m_data [NR];
  logic [NR-1:0]    m_busy;

  function automatic logic [NR*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input string n, input logic [NR-1:0] en,
                              input logic [NR*AW-1:0] ra, input logic we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic ie, input logic [AW-1:0] ia,
                              input logic fl, input int cp,
                              input logic [DW-1:0] ed, input logic eb);
    vec_t v;
    v.name = n; v.en = en; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd;
    v.ie = ie; v.ia = ia; v.fl = fl; v.cp = cp; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int p = 0; p < NR; p++) m_data[p] = '0;
    m_pend = '0;
    m_busy = '0;
  endtask

  task automatic model_step(input vec_t v);
    logic [DEPTH-1:0] np;
    logic             wok;
    int               a;
    wok = v.we && (v.wa != '0);
    np  = m_pend;
    if (wok) np[v.wa] = 1'b0;
    if (v.ie && (v.ia != '0)) np[v.ia] = 1'b1;
    if (v.fl) np = '0;
    for (int p = 0; p < NR; p++) begin
      if (v.en[p]) begin
        a = int'(v.ra[p*AW +: AW]);
        if (a == 0)                     m_data[p] = '0;
        else if (wok && int'(v.wa) == a) m_data[p] = v.wd;
        else                            m_data[p] = m_mem[a];
        m_busy[p] = np[a];
      end
    end
    m_pend = np;
    if (wok) m_mem[v.wa] = v.wd;
  endtask

  task automatic chk_data(input string n, input int p, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s port%0d data: got %h, expected %h", n, p, got, exp);
    end
  endtask

  task automatic chk_bit(input string n, input int p, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s port%0d busy: got %b, expected %b", n, p, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rd_en    = v.en;
    bus.rd_addr  = v.ra;
    bus.wr_en    = v.we;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.iss_en   = v.ie;
    bus.iss_addr = v.ia;
    bus.flush    = v.fl;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      chk_data({v.name, "/model"}, p, bus.rd_data[p*DW +: DW], m_data[p]);
      chk_bit ({v.name, "/model"}, p, bus.rd_busy[p], m_busy[p]);
    end
    if (v.cp >= 0) begin
      chk_data(v.name, v.cp, bus.rd_data[v.cp*DW +: DW], v.ed);
      chk_bit (v.name, v.cp, bus.rd_busy[v.cp], v.eb);
    end
  endtask

  vec_t idle;
  vec_t tbl[$];
  vec_t rv;

  initial begin
    idle = mk("idle", '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, -1, '0, 1'b0);
    drive(idle);
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      chk_data("in_reset", p, bus.rd_data[p*DW +: DW], 64'h0);
      chk_bit ("in_reset", p, bus.rd_busy[p], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      step(mk("rd_all", 4'hF, pk(AW'(a), AW'(a), AW'(a), AW'(a)), 1'b0, '0, '0,
              1'b0, '0, 1'b0, 1, 64'h0, 1'b0));
    end

    tbl.push_back(mk("wr5_bypass",   4'b0001, pk(5'd5,0,0,0), 1'b1, 5'd5, 64'hDEADBEEF00000001, 1'b0, 5'd0, 1'b0, 0, 64'hDEADBEEF00000001, 1'b0));
    tbl.push_back(mk("hold_p0",      4'b0000, pk(5'd0,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'hDEADBEEF00000001, 1'b0));
    tbl.push_back(mk("rd5_array",    4'b0011, pk(5'd5,5'd5,0,0), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 1, 64'hDEADBEEF00000001, 1'b0));
    tbl.push_back(mk("wr0_drop",     4'b0001, pk(5'd0,0,0,0), 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 1'b0, 0, 64'h0, 1'b0));
    tbl.push_back(mk("rd0",          4'b0001, pk(5'd0,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h0, 1'b0));
    tbl.push_back(mk("iss0_rd0",     4'b0001, pk(5'd0,0,0,0), 1'b0, 5'd0, 64'h0,   1'b1, 5'd0, 1'b0, 0, 64'h0, 1'b0));
    tbl.push_back(mk("rd0_notbusy",  4'b0001, pk(5'd0,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h0, 1'b0));
    tbl.push_back(mk("iss7",         4'b0001, pk(5'd5,0,0,0), 1'b0, 5'd0, 64'h0,   1'b1, 5'd7, 1'b0, 0, 64'hDEADBEEF00000001, 1'b0));
    tbl.push_back(mk("rd7_busy",     4'b0001, pk(5'd7,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h0, 1'b1));
    tbl.push_back(mk("wb7_rd7",      4'b0001, pk(5'd7,0,0,0), 1'b1, 5'd7, 64'h42,  1'b0, 5'd0, 1'b0, 0, 64'h42, 1'b0));
    tbl.push_back(mk("iss_wb9",      4'b0001, pk(5'd9,0,0,0), 1'b1, 5'd9, 64'h99,  1'b1, 5'd9, 1'b0, 0, 64'h99, 1'b1));
    tbl.push_back(mk("rd9_busy",     4'b0001, pk(5'd9,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h99, 1'b1));
    tbl.push_back(mk("set1",         4'b0001, pk(5'd1,0,0,0), 1'b1, 5'd1, 64'h11,  1'b1, 5'd1, 1'b0, 0, 64'h11, 1'b1));
    tbl.push_back(mk("set2",         4'b0001, pk(5'd2,0,0,0), 1'b1, 5'd2, 64'h22,  1'b1, 5'd2, 1'b0, 0, 64'h22, 1'b1));
    tbl.push_back(mk("set3",         4'b0001, pk(5'd3,0,0,0), 1'b1, 5'd3, 64'h33,  1'b1, 5'd3, 1'b0, 0, 64'h33, 1'b1));
    tbl.push_back(mk("flush_iss4",   4'b1111, pk(5'd4,5'd1,5'd2,5'd3), 1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 1'b1, 0, 64'h0, 1'b0));
    tbl.push_back(mk("post_flush1",  4'b1111, pk(5'd1,5'd2,5'd3,5'd4), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 0, 64'h11, 1'b0));
    tbl.push_back(mk("post_flush3",  4'b0001, pk(5'd3,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h33, 1'b0));
    tbl.push_back(mk("wr12_all",     4'b1111, pk(5'd12,5'd12,5'd12,5'd12), 1'b1, 5'd12, 64'h1234, 1'b0, 5'd0, 1'b0, 3, 64'h1234, 1'b0));
    tbl.push_back(mk("p2_hold",      4'b1011, pk(5'd5,5'd1,5'd9,5'd2), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 2, 64'h1234, 1'b0));
    tbl.push_back(mk("p2_hold_p1",   4'b1011, pk(5'd5,5'd1,5'd9,5'd2), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 1, 64'h11, 1'b0));
    tbl.push_back(mk("wr3_55",       4'b0001, pk(5'd3,0,0,0), 1'b1, 5'd3, 64'h55,  1'b0, 5'd0, 1'b0, 0, 64'h55, 1'b0));
    tbl.push_back(mk("rd3_55",       4'b0001, pk(5'd3,0,0,0), 1'b0, 5'd0, 64'h0,   1'b0, 5'd0, 1'b0, 0, 64'h55, 1'b0));

    foreach (tbl[i]) step(tbl[i]);

    // Mid-cycle reset with a write in flight: outputs clear at once, write lost
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 64'h77;
    reset_n     = 1'b0;
    #1;
    chk_data("async_reset", 0, bus.rd_data[DW-1:0], 64'h0);
    chk_bit ("async_reset", 0, bus.rd_busy[0], 1'b0);
    model_reset();
    @(posedge clk);
    drive(idle);
    @(negedge clk);
    reset_n = 1'b1;
    step(mk("rd3_after_rst", 4'b0001, pk(5'd3,0,0,0), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 0, 64'h0, 1'b0));

    for (int n = 0; n < 600; n++) begin
      rv = idle;
      rv.name = "rand";
      rv.en   = NR'($urandom);
      for (int p = 0; p < NR; p++) begin
        rv.ra[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      rv.we = ($urandom_range(0, 1) == 1);
      rv.wa = AW'($urandom_range(0, 7));
      rv.wd = {$urandom, $urandom};
      rv.ie = ($urandom_range(0, 4) < 2);
      rv.ia = AW'($urandom_range(0, 7));
      rv.fl = ($urandom_range(0, 19) == 0);
      step(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
